// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin multi-approach signal controller with
// demand-extended green, all-red clearance and a latched pedestrian walk phase.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 4,
    parameter int TIMER_W    = 8,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 15,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int WALK_T     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PHASES-1:0]         car_req,
    input  logic                          ped_button,
    output logic [2*NUM_PHASES-1:0]       light,
    output logic                          walk_signal,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          ped_pending
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam int CW = PW + 1;
    localparam logic [TIMER_W-1:0] ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] G_MIN = TIMER_W'(GREEN_MIN);
    localparam logic [TIMER_W-1:0] G_MAX = TIMER_W'(GREEN_MAX);
    localparam logic [TIMER_W-1:0] Y_T   = TIMER_W'(YELLOW_T);
    localparam logic [TIMER_W-1:0] AR_T  = TIMER_W'(ALLRED_T);
    localparam logic [TIMER_W-1:0] W_T   = TIMER_W'(WALK_T);

    typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALL_RED, PED_WALK} state_e;

    state_e                  state_q, state_d;
    logic [TIMER_W-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]           ap_q, ap_d, winner;
    logic [CW-1:0]           cand;
    logic [2*NUM_PHASES-1:0] light_q, light_d;
    logic                    walk_q, walk_d, ped_q, ped_d;
    logic                    any_req, own_req, other_req, decide;

    // Round-robin search starting after the current phase; own phase is checked last.
    always_comb begin
        winner = ap_q;
        cand = '0;
        for (int j = NUM_PHASES; j >= 1; j--) begin
            cand = {1'b0, ap_q} + CW'(j);
            if (cand >= CW'(NUM_PHASES)) cand = cand - CW'(NUM_PHASES);
            if (car_req[cand[PW-1:0]]) winner = cand[PW-1:0];
        end
    end

    always_comb begin
        any_req = |car_req;
        own_req = car_req[ap_q];
        other_req = |(car_req & ~(NUM_PHASES'(1) << ap_q));
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        ap_d = ap_q;
        decide = 1'b0;
        case (state_q)
            IDLE: decide = 1'b1;
            GREEN: if (cnt_q == G_MAX || (cnt_q >= G_MIN && (other_req || ped_q || !own_req))) begin
                state_d = YELLOW;
                cnt_d = ONE;
            end
            YELLOW: if (cnt_q == Y_T) begin
                state_d = ALL_RED;
                cnt_d = ONE;
            end
            ALL_RED: decide = cnt_q == AR_T;
            PED_WALK: if (cnt_q == W_T) begin
                state_d = any_req ? GREEN : ped_q ? PED_WALK : IDLE;
                cnt_d = (any_req || ped_q) ? ONE : '0;
                ap_d = any_req ? winner : ap_q;
            end
            default: state_d = IDLE;
        endcase
        if (decide) begin
            state_d = ped_q ? PED_WALK : any_req ? GREEN : IDLE;
            cnt_d = (ped_q || any_req) ? ONE : '0;
            ap_d = (!ped_q && any_req) ? winner : ap_q;
        end
        // Entering (or re-entering) the walk clears the latch; a same-edge press is absorbed.
        ped_d = (state_d == PED_WALK && cnt_d == ONE) ? 1'b0 : (ped_q | ped_button);
        walk_d = state_d == PED_WALK;
        light_d = '0;
        for (int i = 0; i < NUM_PHASES; i++)
            light_d[2*i +: 2] = (PW'(i) != ap_d) ? 2'b00 :
                                (state_d == GREEN) ? 2'b01 :
                                (state_d == YELLOW) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            ap_q <= PW'(NUM_PHASES - 1);
            ped_q <= 1'b0;
            light_q <= '0;
            walk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            ap_q <= ap_d;
            ped_q <= ped_d;
            light_q <= light_d;
            walk_q <= walk_d;
        end
    end

    assign light = light_q;
    assign walk_signal = walk_q;
    assign active_phase = ap_q;
    assign ped_pending = ped_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed vectors and hand-computed lamp sequences for
// the default-parameter traffic_phase_ctrl.
module tb_traffic_phase_ctrl;
    localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] car_req = '0;
    logic       ped_button = 1'b0;
    logic [7:0] light;
    logic       walk_signal;
    logic [1:0] active_phase;
    logic       ped_pending;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic [3:0] car;
        logic       ped;
        int         n;
        logic [7:0] l;
        logic       w;
        logic [1:0] a;
        logic       p;
    } vec_t;
    vec_t tbl[7];

    traffic_phase_ctrl dut (
        .clk(clk),
        .rst(rst),
        .car_req(car_req),
        .ped_button(ped_button),
        .light(light),
        .walk_signal(walk_signal),
        .active_phase(active_phase),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lamp(input int ph, input logic [1:0] c);
        lamp = '0;
        lamp[2*ph +: 2] = c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] l, input logic w,
                           input logic [1:0] a, input logic p);
        chk({nm, ".light"}, 32'(light), 32'(l));
        chk({nm, ".walk"}, 32'(walk_signal), 32'(w));
        chk({nm, ".phase"}, 32'(active_phase), 32'(a));
        chk({nm, ".ped"}, 32'(ped_pending), 32'(p));
    endtask

    task automatic run(input string nm, input int n, input logic [7:0] l, input logic w,
                       input logic [1:0] a, input logic p);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            chk_all(nm, l, w, a, p);
        end
    endtask

    task automatic do_reset(input logic [3:0] car);
        rst = 1'b1;
        car_req = car;
        ped_button = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 1'b0, 2'd3, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 1, lamp(0, G), 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'b0001, 1'b1, 1, lamp(0, G), 1'b0, 2'd0, 1'b1};
        tbl[2] = '{4'b0001, 1'b0, 3, lamp(0, G), 1'b0, 2'd0, 1'b1};
        tbl[3] = '{4'b0001, 1'b0, 2, lamp(0, Y), 1'b0, 2'd0, 1'b1};
        tbl[4] = '{4'b0001, 1'b0, 1, 8'h00,      1'b0, 2'd0, 1'b1};
        tbl[5] = '{4'b0001, 1'b0, 4, 8'h00,      1'b1, 2'd0, 1'b0};
        tbl[6] = '{4'b0001, 1'b0, 2, lamp(0, G), 1'b0, 2'd0, 1'b0};

        // Lone held request: extension to the maximum green.
        do_reset(4'b0010);
        run("s1_green", 15, lamp(1, G), 1'b0, 2'd1, 1'b0);
        run("s1_yellow", 2, lamp(1, Y), 1'b0, 2'd1, 1'b0);
        run("s1_allred", 1, 8'h00, 1'b0, 2'd1, 1'b0);
        run("s1_regreen", 1, lamp(1, G), 1'b0, 2'd1, 1'b0);

        // Competing demand ends green at the minimum.
        do_reset(4'b0001);
        run("s2_green", 2, lamp(0, G), 1'b0, 2'd0, 1'b0);
        car_req = 4'b0101;
        run("s2_green", 3, lamp(0, G), 1'b0, 2'd0, 1'b0);
        run("s2_yellow", 2, lamp(0, Y), 1'b0, 2'd0, 1'b0);
        run("s2_allred", 1, 8'h00, 1'b0, 2'd0, 1'b0);
        run("s2_next", 1, lamp(2, G), 1'b0, 2'd2, 1'b0);

        // Full demand: round-robin order 0,1,2,3,0.
        do_reset(4'b1111);
        for (int k = 0; k < 5; k++) begin
            run("s3_green", 5, lamp(k % 4, G), 1'b0, 2'(k % 4), 1'b0);
            if (k < 4) begin
                run("s3_yellow", 2, lamp(k % 4, Y), 1'b0, 2'(k % 4), 1'b0);
                run("s3_allred", 1, 8'h00, 1'b0, 2'(k % 4), 1'b0);
            end
        end

        // Pedestrian press during green, table driven.
        do_reset(4'b0001);
        for (int r = 0; r < 7; r++) begin
            car_req = tbl[r].car;
            ped_button = tbl[r].ped;
            run($sformatf("s4_row%0d", r), tbl[r].n, tbl[r].l, tbl[r].w, tbl[r].a, tbl[r].p);
        end
        ped_button = 1'b0;

        // Press during a walk re-latches and triggers a second walk.
        do_reset(4'b0000);
        ped_button = 1'b1;
        run("s5_latch", 1, 8'h00, 1'b0, 2'd3, 1'b1);
        ped_button = 1'b0;
        run("s5_walk1", 1, 8'h00, 1'b1, 2'd3, 1'b0);
        ped_button = 1'b1;
        run("s5_relatch", 1, 8'h00, 1'b1, 2'd3, 1'b1);
        ped_button = 1'b0;
        run("s5_walk1", 2, 8'h00, 1'b1, 2'd3, 1'b1);
        run("s5_walk2", 4, 8'h00, 1'b1, 2'd3, 1'b0);
        run("s5_idle", 2, 8'h00, 1'b0, 2'd3, 1'b0);

        // Asynchronous reset in the middle of yellow.
        do_reset(4'b0011);
        ped_button = 1'b1;
        run("s6_green", 1, lamp(0, G), 1'b0, 2'd0, 1'b1);
        ped_button = 1'b0;
        run("s6_green", 4, lamp(0, G), 1'b0, 2'd0, 1'b1);
        run("s6_yellow", 1, lamp(0, Y), 1'b0, 2'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("s6_async_rst", 8'h00, 1'b0, 2'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
